// File: rtl/fir_cfg_pkg.sv
// Shared types and constants for the fir_interpolator configuration sequencer.
// Holds the state encoding, coefficient-count helpers and div legality bounds.
package fir_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        LOAD,
        SETTLE
    } cfg_state_e;

    localparam int ORD_DEF = 255;
    localparam int M_DEF   = 8;
    localparam int NCOEF   = (ORD_DEF + 1) / 2;
    localparam int DIV_MIN = 1;
    localparam int DIV_MAX = M_DEF / 2;

    function automatic int ncoef_of(input int ord);
        return (ord + 1) / 2;
    endfunction

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int div_max_of(input int m);
        return m / 2;
    endfunction

endpackage

// File: rtl/cfg_timeout_cnt.sv
// Loadable down-counter with an expire flag; shared for drain/timeout/settle.
// Ports: clk, rst, load/load_val reload, en decrements, expired when zero.
module cfg_timeout_cnt #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/fir_interp_cfg_ctrl.sv
// Sequencer that closes the sample path, drains, loads coefficients, reopens.
// Ports: cfg_* control, coef_* host stream, s_* samples, fir_* interpolator.
module fir_interp_cfg_ctrl
    import fir_cfg_pkg::*;
#(
    parameter int ORD         = ORD_DEF,
    parameter int M           = M_DEF,
    parameter int COEFF_SIZE  = 16,
    parameter int SAMPLE_SIZE = 16,
    parameter int DRAIN_CYC   = 800,
    parameter int TIMEOUT     = 1023
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_start,
    input  logic [$clog2(M/2+1)-1:0]        cfg_div,
    output logic                            cfg_busy,
    output logic                            cfg_done,
    output logic                            cfg_err,
    input  logic                            coef_valid,
    output logic                            coef_ready,
    input  logic [COEFF_SIZE-1:0]           coef_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [SAMPLE_SIZE-1:0]          s_data,
    output logic                            fir_valid_in,
    output logic [SAMPLE_SIZE-1:0]          fir_din,
    output logic [$clog2(M/2+1)-1:0]        fir_div,
    output logic                            fir_c_we,
    output logic [addr_w(ncoef_of(ORD))-1:0] fir_c_addr,
    output logic [COEFF_SIZE-1:0]           fir_c_in
);

    localparam int NC   = ncoef_of(ORD);
    localparam int AW   = addr_w(NC);
    localparam int DW   = $clog2(M/2+1);
    localparam int CMAX = (DRAIN_CYC > TIMEOUT) ? DRAIN_CYC : TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    cfg_state_e    state, state_n;
    logic [DW-1:0] div_lat;
    logic [AW-1:0] beat_idx;
    logic          load_ok;
    logic          hs, last_beat, div_ok;
    logic          cnt_load, cnt_en, cnt_exp;
    logic [CW-1:0] cnt_val;
    logic          err_n, done_n, start_ok;

    assign s_ready      = (state == IDLE);
    assign fir_valid_in = s_valid && s_ready;
    assign fir_din      = s_data;
    assign cfg_busy     = (state != IDLE);
    assign coef_ready   = (state == LOAD);
    assign hs           = coef_valid && coef_ready;
    assign last_beat    = (beat_idx == AW'(NC - 1));
    assign div_ok       = (cfg_div >= DW'(DIV_MIN)) &&
                          (cfg_div <= DW'(div_max_of(M)));

    cfg_timeout_cnt #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .expired  (cnt_exp)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // One counter serves every timed phase; it is reloaded on each entry.
    always_comb begin
        state_n  = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_en   = 1'b0;
        err_n    = 1'b0;
        done_n   = 1'b0;
        start_ok = 1'b0;
        unique case (state)
            IDLE: begin
                if (cfg_start) begin
                    if (div_ok) begin
                        start_ok = 1'b1;
                        state_n  = DRAIN;
                        cnt_load = 1'b1;
                        cnt_val  = CW'(DRAIN_CYC - 1);
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (cnt_exp) begin
                    state_n  = LOAD;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(TIMEOUT - 1);
                end else begin
                    cnt_en = 1'b1;
                end
            end
            LOAD: begin
                if (hs) begin
                    cnt_load = 1'b1;
                    if (last_beat) begin
                        state_n = SETTLE;
                        cnt_val = CW'(1);
                    end else begin
                        cnt_val = CW'(TIMEOUT - 1);
                    end
                end else if (cnt_exp) begin
                    state_n  = SETTLE;
                    err_n    = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(1);
                end else begin
                    cnt_en = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_exp) begin
                    state_n = IDLE;
                    done_n  = load_ok;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fir_c_we   <= 1'b0;
            fir_c_addr <= '0;
            fir_c_in   <= '0;
            fir_div    <= DW'(1);
            div_lat    <= DW'(1);
            beat_idx   <= '0;
            load_ok    <= 1'b0;
            cfg_err    <= 1'b0;
            cfg_done   <= 1'b0;
        end else begin
            fir_c_we <= hs;
            cfg_err  <= err_n;
            cfg_done <= done_n;
            if (hs) begin
                fir_c_addr <= beat_idx;
                fir_c_in   <= coef_data;
                beat_idx   <= beat_idx + AW'(1);
                if (last_beat) load_ok <= 1'b1;
            end
            if (start_ok) begin
                div_lat <= cfg_div;
                load_ok <= 1'b0;
            end
            // div only changes once the pipeline is empty.
            if (state == DRAIN && cnt_exp) begin
                fir_div  <= div_lat;
                beat_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fir_interp_cfg_ctrl.sv
// Directed bench for fir_interp_cfg_ctrl.
// Covers reset, bad div, full loads, timeout and reset mid-load.
module tb_fir_interp_cfg_ctrl;

    localparam int NC    = 128;
    localparam int DRAIN = 800;
    localparam int TO    = 1023;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [2:0]  cfg_div = 3'd0;
    logic        cfg_busy, cfg_done, cfg_err;
    logic        coef_valid = 1'b0;
    logic        coef_ready;
    logic [15:0] coef_data = 16'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = 16'd0;
    logic        fir_valid_in;
    logic [15:0] fir_din;
    logic [2:0]  fir_div;
    logic        fir_c_we;
    logic [6:0]  fir_c_addr;
    logic [15:0] fir_c_in;

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [6:0] wr_addr[$];
    logic [2:0] exp_div = 3'd1;

    fir_interp_cfg_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_start    (cfg_start),
        .cfg_div      (cfg_div),
        .cfg_busy     (cfg_busy),
        .cfg_done     (cfg_done),
        .cfg_err      (cfg_err),
        .coef_valid   (coef_valid),
        .coef_ready   (coef_ready),
        .coef_data    (coef_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .fir_valid_in (fir_valid_in),
        .fir_din      (fir_din),
        .fir_div      (fir_div),
        .fir_c_we     (fir_c_we),
        .fir_c_addr   (fir_c_addr),
        .fir_c_in     (fir_c_in)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fir_c_we) wr_addr.push_back(fir_c_addr);
        if (cfg_done) done_cnt++;
        if (cfg_err) err_cnt++;
        n_chk++;
        if (fir_c_we && fir_valid_in) begin
            n_fail++;
            $display("FAIL invariant: c_we=%b valid_in=%b required not both 1",
                     fir_c_we, fir_valid_in);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        done_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_chk++;
        if ({cfg_busy, cfg_done, cfg_err, coef_ready, fir_c_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 00000",
                     {cfg_busy, cfg_done, cfg_err, coef_ready, fir_c_we});
        end
        n_chk++;
        if (fir_c_addr !== 7'd0 || fir_c_in !== 16'd0 ||
            fir_div !== 3'd1 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_regs: addr=%0d c_in=%0h div=%0d s_ready=%b required 0 0 1 1",
                     fir_c_addr, fir_c_in, fir_div, s_ready);
        end
        s_valid = 1'b1;
        s_data  = 16'hABCD;
        #1;
        n_chk++;
        if (fir_valid_in !== 1'b1 || fir_din !== 16'hABCD) begin
            n_fail++;
            $display("FAIL passthru_on: valid=%b din=%0h required 1 abcd",
                     fir_valid_in, fir_din);
        end
        s_valid = 1'b0;
        #1;
        n_chk++;
        if (fir_valid_in !== 1'b0) begin
            n_fail++;
            $display("FAIL passthru_off: valid=%b required 0", fir_valid_in);
        end
        tick();
    endtask

    task automatic test_bad_div(input logic [2:0] d);
        clear_mon();
        cfg_div   = d;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        n_chk++;
        if (cfg_err !== 1'b1 || cfg_busy !== 1'b0 ||
            s_ready !== 1'b1 || fir_div !== exp_div) begin
            n_fail++;
            $display("FAIL bad_div_%0d: err=%b busy=%b s_ready=%b div=%0d required 1 0 1 %0d",
                     d, cfg_err, cfg_busy, s_ready, fir_div, exp_div);
        end
        tick();
        n_chk++;
        if (cfg_err !== 1'b0 || err_cnt != 1) begin
            n_fail++;
            $display("FAIL bad_div_pulse_%0d: err=%b pulses=%0d required 0 1",
                     d, cfg_err, err_cnt);
        end
    endtask

    task automatic start_and_drain(input logic [2:0] d);
        clear_mon();
        cfg_div   = d;
        cfg_start = 1'b1;
        s_valid   = 1'b1;
        s_data    = 16'h1234;
        #1;
        n_chk++;
        if (fir_valid_in !== 1'b1 || fir_din !== 16'h1234) begin
            n_fail++;
            $display("FAIL start_fwd: valid=%b din=%0h required 1 1234",
                     fir_valid_in, fir_din);
        end
        tick();
        cfg_start = 1'b0;
        n_chk++;
        if (s_ready !== 1'b0 || cfg_busy !== 1'b1 || fir_valid_in !== 1'b0) begin
            n_fail++;
            $display("FAIL closed: s_ready=%b busy=%b valid=%b required 0 1 0",
                     s_ready, cfg_busy, fir_valid_in);
        end
        coef_valid = 1'b1;
        coef_data  = 16'hDEAD;
        repeat (DRAIN - 1) tick();
        n_chk++;
        if (coef_ready !== 1'b0 || fir_div !== exp_div || wr_addr.size() != 0) begin
            n_fail++;
            $display("FAIL drain_end: ready=%b div=%0d writes=%0d required 0 %0d 0",
                     coef_ready, fir_div, wr_addr.size(), exp_div);
        end
        coef_valid = 1'b0;
        tick();
        n_chk++;
        if (coef_ready !== 1'b1 || fir_div !== d || wr_addr.size() != 0) begin
            n_fail++;
            $display("FAIL load_entry: ready=%b div=%0d writes=%0d required 1 %0d 0",
                     coef_ready, fir_div, wr_addr.size(), d);
        end
        exp_div = d;
    endtask

    task automatic test_full_load(input logic [2:0] d, input bit throttle);
        int k;
        int cyc;
        int bad;
        logic v;
        logic hs;
        start_and_drain(d);
        k = 0;
        cyc = 0;
        bad = 0;
        while (k < NC && cyc < 5000) begin
            v = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            coef_valid = v;
            coef_data  = 16'(k + 100);
            hs = v && coef_ready;
            tick();
            cyc++;
            if (hs) begin
                if (fir_c_we !== 1'b1 || fir_c_addr !== 7'(k) ||
                    fir_c_in !== 16'(k + 100)) begin
                    bad++;
                    if (bad < 4)
                        $display("FAIL write_%0d: we=%b addr=%0d c_in=%0d required 1 %0d %0d",
                                 k, fir_c_we, fir_c_addr, fir_c_in, k, k + 100);
                end
                k++;
            end else if (fir_c_we !== 1'b0) begin
                bad++;
                if (bad < 4)
                    $display("FAIL idle_we: we=%b required 0", fir_c_we);
            end
        end
        coef_valid = 1'b0;
        n_chk++;
        if (bad != 0 || k != NC) begin
            n_fail++;
            $display("FAIL beats: bad=%0d accepted=%0d required 0 %0d", bad, k, NC);
        end
        n_chk++;
        if (coef_ready !== 1'b0 || cfg_busy !== 1'b1 || fir_c_we !== 1'b1) begin
            n_fail++;
            $display("FAIL last_beat: ready=%b busy=%b we=%b required 0 1 1",
                     coef_ready, cfg_busy, fir_c_we);
        end
        tick();
        n_chk++;
        if (cfg_busy !== 1'b1 || cfg_done !== 1'b0 || fir_c_we !== 1'b0) begin
            n_fail++;
            $display("FAIL settle2: busy=%b done=%b we=%b required 1 0 0",
                     cfg_busy, cfg_done, fir_c_we);
        end
        tick();
        n_chk++;
        if (cfg_done !== 1'b1 || cfg_busy !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL done: done=%b busy=%b s_ready=%b required 1 0 1",
                     cfg_done, cfg_busy, s_ready);
        end
        tick();
        bad = 0;
        for (int i = 0; i < wr_addr.size(); i++)
            if (wr_addr[i] !== 7'(i)) bad++;
        n_chk++;
        if (cfg_done !== 1'b0 || done_cnt != 1 || err_cnt != 0 ||
            wr_addr.size() != NC || bad != 0) begin
            n_fail++;
            $display("FAIL load_summary: done=%b dones=%0d errs=%0d writes=%0d bad_addr=%0d required 0 1 0 %0d 0",
                     cfg_done, done_cnt, err_cnt, wr_addr.size(), bad, NC);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_timeout();
        start_and_drain(3'd3);
        for (int i = 0; i < 11; i++) begin
            coef_valid = 1'b1;
            coef_data  = 16'(i + 100);
            tick();
        end
        coef_valid = 1'b0;
        repeat (TO - 1) tick();
        n_chk++;
        if (cfg_err !== 1'b0 || coef_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL to_early: err=%b ready=%b required 0 1", cfg_err, coef_ready);
        end
        tick();
        n_chk++;
        if (cfg_err !== 1'b1 || coef_ready !== 1'b0 || cfg_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL to_abort: err=%b ready=%b busy=%b required 1 0 1",
                     cfg_err, coef_ready, cfg_busy);
        end
        tick();
        tick();
        n_chk++;
        if (cfg_busy !== 1'b0 || cfg_done !== 1'b0 || s_ready !== 1'b1 ||
            fir_div !== 3'd3) begin
            n_fail++;
            $display("FAIL to_idle: busy=%b done=%b s_ready=%b div=%0d required 0 0 1 3",
                     cfg_busy, cfg_done, s_ready, fir_div);
        end
        n_chk++;
        if (wr_addr.size() != 11 || done_cnt != 0 || err_cnt != 1) begin
            n_fail++;
            $display("FAIL to_summary: writes=%0d dones=%0d errs=%0d required 11 0 1",
                     wr_addr.size(), done_cnt, err_cnt);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        start_and_drain(3'd2);
        for (int i = 0; i < 64; i++) begin
            coef_valid = 1'b1;
            coef_data  = 16'(i + 100);
            tick();
        end
        coef_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_div = 3'd1;
        n_chk++;
        if (cfg_busy !== 1'b0 || coef_ready !== 1'b0 || fir_c_we !== 1'b0 ||
            fir_c_addr !== 7'd0 || fir_div !== 3'd1) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b ready=%b we=%b addr=%0d div=%0d required 0 0 0 0 1",
                     cfg_busy, coef_ready, fir_c_we, fir_c_addr, fir_div);
        end
        repeat (3) tick();
        n_chk++;
        if (done_cnt != 0 || err_cnt != 0) begin
            n_fail++;
            $display("FAIL mid_pulses: dones=%0d errs=%0d required 0 0",
                     done_cnt, err_cnt);
        end
        s_valid = 1'b0;
        test_full_load(3'd4, 1'b0);
    endtask

    initial begin
        test_reset();
        test_full_load(3'd2, 1'b0);
        test_bad_div(3'd0);
        test_bad_div(3'd5);
        test_timeout();
        test_full_load(3'd1, 1'b1);
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
